// File: rtl/amp_pkg.sv
// Shared types and widths for the instruction-memory loader.
package amp_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs incoming bytes little-endian into a word; one byte per load_byte, no stall.
// last_byte flags that the next accepted byte completes the word.
module word_assembler
  import amp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_byte,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              last_byte
);

  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] lanes_q, lanes_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    lanes_d    = lanes_q;
    if (clear) begin
      byte_idx_d = '0;
      lanes_d    = '0;
    end else if (load_byte) begin
      lanes_d[int'(byte_idx_q) * BYTE_W +: BYTE_W] = byte_in;
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx_q <= '0;
      lanes_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
    end
  end

  assign word_out  = lanes_q;
  assign last_byte = (byte_idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Fills instruction RAM from a byte stream and holds the core in reset until the image is in.
// One write cycle per word (4 bytes / 5 cycles peak); byte_ready drops outside COLLECT.
module prog_loader
  import amp_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW:0]       word_count,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              mem_write_enable,
  output logic [AW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_data_in,
  output logic              core_hold,
  output logic              busy,
  output logic              done
);

  loader_state_t     state_q, state_d;
  logic [AW-1:0]     word_addr_q, word_addr_d;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_data_q, mem_data_d;

  logic              asm_clear;
  logic              asm_load;
  logic [WORD_W-1:0] asm_word;
  logic              asm_last;
  logic [AW:0]       count_clamped;
  logic [AW:0]       next_addr;

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .load_byte (asm_load),
    .byte_in   (byte_data),
    .word_out  (asm_word),
    .last_byte (asm_last)
  );

  assign count_clamped = (word_count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : word_count;
  assign next_addr     = {1'b0, word_addr_q} + (AW+1)'(1);
  assign asm_load      = (state_q == COLLECT) && byte_valid;

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    asm_clear   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (word_count == '0) begin
            state_d = DONE;
          end else begin
            state_d     = COLLECT;
            word_addr_d = '0;
            count_d     = count_clamped;
            asm_clear   = 1'b1;
          end
        end
      end
      COLLECT: begin
        // The final byte bypasses the lane register so the write can issue next cycle.
        if (byte_valid && asm_last) begin
          state_d    = WRITE;
          mem_addr_d = word_addr_q;
          mem_data_d = {byte_data, asm_word[WORD_W-BYTE_W-1:0]};
        end
      end
      WRITE: begin
        asm_clear = 1'b1;
        if (next_addr == count_q) begin
          state_d = DONE;
        end else begin
          state_d     = COLLECT;
          word_addr_d = word_addr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign byte_ready       = (state_q == COLLECT);
  assign mem_write_enable = (state_q == WRITE);
  assign mem_addr         = mem_addr_q;
  assign mem_data_in      = mem_data_q;
  assign core_hold        = (state_q != DONE);
  assign busy             = (state_q == COLLECT) || (state_q == WRITE);
  assign done             = (state_q == DONE);

endmodule
